// File: rtl/wb_arbiter_pkg.sv
// Shared types and constants for the writeback arbiter: register address width,
// writeback source encoding and the load-return queue entry.
package wb_arbiter_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned DATA_W     = 32;

    typedef enum logic [1:0] {
        WB_NONE  = 2'd0,
        WB_ALU   = 2'd1,
        WB_LDQ   = 2'd2,
        WB_LDDIR = 2'd3
    } wb_src_e;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } wb_req_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Bus bundle between the ALU/memory/decode side and the writeback arbiter.
// Signal direction suffixes are from the arbiter's point of view.
interface wb_arbiter_if
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  alu_valid_i;
    logic [REG_ADDR_W-1:0] alu_rd_i;
    logic [DATA_WIDTH-1:0] alu_data_i;
    logic                  alu_stall_o;
    logic                  ld_issue_i;
    logic [REG_ADDR_W-1:0] ld_issue_rd_i;
    logic                  ld_valid_i;
    logic [REG_ADDR_W-1:0] ld_rd_i;
    logic [DATA_WIDTH-1:0] ld_data_i;
    logic                  ld_ready_o;
    logic [REG_ADDR_W-1:0] w_addr_o;
    logic [DATA_WIDTH-1:0] din_o;
    logic [31:0]           busy_o;

    modport slave (
        input  alu_valid_i, alu_rd_i, alu_data_i, ld_issue_i, ld_issue_rd_i,
               ld_valid_i, ld_rd_i, ld_data_i,
        output alu_stall_o, ld_ready_o, w_addr_o, din_o, busy_o
    );

    modport master (
        output alu_valid_i, alu_rd_i, alu_data_i, ld_issue_i, ld_issue_rd_i,
               ld_valid_i, ld_rd_i, ld_data_i,
        input  alu_stall_o, ld_ready_o, w_addr_o, din_o, busy_o
    );
endinterface

// File: rtl/wb_arbiter_ld_fifo.sv
// Small synchronous FIFO holding load returns that lost arbitration.
// DEPTH must be a power of two so the pointers wrap naturally.
module wb_ld_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  wb_req_t          push_data_i,
    input  logic             pop_i,
    output wb_req_t          head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    wb_req_t          mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty_o   = (count_q == CNT_W'(0));
    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign count_o   = count_q;
    assign head_o    = mem_q[rd_ptr_q];
    assign do_pop_s  = pop_i && !empty_o;
    // A pop frees a slot in the same cycle, so a push into a full queue is still safe.
    assign do_push_s = push_i && (!full_o || do_pop_s);

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push_s) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges in-order ALU results with buffered load returns onto
// the single register-file write port and tracks outstanding loads per register.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_W,
    parameter int unsigned LQ_DEPTH   = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    wb_arbiter_if.slave  bus
);

    localparam int unsigned ST_W  = $clog2(STARVE_MAX + 1);
    localparam int unsigned CNT_W = $clog2(LQ_DEPTH) + 1;

    wb_req_t               head_s;
    wb_req_t               push_req_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic [CNT_W-1:0]      fifo_count_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  ld_ready_s;
    logic                  ld_acc_s;
    logic                  ld_keep_s;
    logic                  force_ld_s;
    wb_src_e               src_s;
    logic [REG_ADDR_W-1:0] sel_rd_s;
    logic [DATA_WIDTH-1:0] sel_data_s;
    logic [31:0]           busy_set_s;
    logic [31:0]           busy_clr_s;

    logic [ST_W-1:0]       starve_q, starve_d;
    logic [31:0]           busy_q, busy_d;
    logic [REG_ADDR_W-1:0] w_addr_q, w_addr_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;

    wb_ld_fifo #(.DEPTH(LQ_DEPTH)) u_ld_fifo (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .push_i      (push_s),
        .push_data_i (push_req_s),
        .pop_i       (pop_s),
        .head_o      (head_s),
        .full_o      (fifo_full_s),
        .empty_o     (fifo_empty_s),
        .count_o     (fifo_count_s)
    );

    // Both handshake outputs depend on registered state only, never on this cycle's valids.
    assign ld_ready_s      = !fifo_full_s;
    assign force_ld_s      = (fifo_count_s != CNT_W'(0)) && (starve_q == ST_W'(STARVE_MAX));
    assign ld_acc_s        = bus.ld_valid_i && ld_ready_s;
    assign ld_keep_s       = ld_acc_s && (bus.ld_rd_i != REG_ADDR_W'(0));
    assign push_req_s.rd   = bus.ld_rd_i;
    assign push_req_s.data = bus.ld_data_i;

    // Source selection in priority order and the resulting queue push/pop.
    always_comb begin
        src_s      = WB_NONE;
        pop_s      = 1'b0;
        sel_rd_s   = '0;
        sel_data_s = '0;
        if (force_ld_s) begin
            src_s = WB_LDQ;
        end else if (bus.alu_valid_i && (bus.alu_rd_i != REG_ADDR_W'(0))) begin
            src_s = WB_ALU;
        end else if (!fifo_empty_s) begin
            src_s = WB_LDQ;
        end else if (ld_keep_s) begin
            src_s = WB_LDDIR;
        end else begin
            src_s = WB_NONE;
        end
        case (src_s)
            WB_ALU: begin
                sel_rd_s   = bus.alu_rd_i;
                sel_data_s = bus.alu_data_i;
            end
            WB_LDQ: begin
                sel_rd_s   = head_s.rd;
                sel_data_s = head_s.data;
                pop_s      = 1'b1;
            end
            WB_LDDIR: begin
                sel_rd_s   = bus.ld_rd_i;
                sel_data_s = bus.ld_data_i;
            end
            default: begin
                sel_rd_s   = '0;
                sel_data_s = '0;
            end
        endcase
        push_s = ld_keep_s && (src_s != WB_LDDIR);
    end

    // Next-state for the starvation counter, busy scoreboard and write port.
    always_comb begin
        starve_d   = starve_q;
        busy_set_s = '0;
        busy_clr_s = '0;
        if ((src_s == WB_LDQ) || (src_s == WB_LDDIR)) begin
            starve_d              = '0;
            busy_clr_s[sel_rd_s]  = 1'b1;
        end else if (fifo_empty_s) begin
            starve_d = '0;
        end else if ((src_s == WB_ALU) && (starve_q != ST_W'(STARVE_MAX))) begin
            starve_d = starve_q + ST_W'(1);
        end else begin
            starve_d = starve_q;
        end
        if (bus.ld_issue_i && (bus.ld_issue_rd_i != REG_ADDR_W'(0))) begin
            busy_set_s[bus.ld_issue_rd_i] = 1'b1;
        end else begin
            busy_set_s = '0;
        end
        // Set after clear so a same-cycle re-issue keeps the register busy.
        busy_d   = ((busy_q & ~busy_clr_s) | busy_set_s) & ~32'd1;
        w_addr_d = sel_rd_s;
        din_d    = sel_data_s;
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            starve_q <= '0;
            busy_q   <= '0;
            w_addr_q <= '0;
            din_q    <= '0;
        end else begin
            starve_q <= starve_d;
            busy_q   <= busy_d;
            w_addr_q <= w_addr_d;
            din_q    <= din_d;
        end
    end

    assign bus.alu_stall_o = force_ld_s;
    assign bus.ld_ready_o  = ld_ready_s;
    assign bus.w_addr_o    = w_addr_q;
    assign bus.din_o       = din_q;
    assign bus.busy_o      = busy_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: a queue-based reference model predicts each
// write, a monitor pops predictions whenever the register-file port is written.
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    localparam int DW   = 32;
    localparam int LQD  = 2;
    localparam int SMAX = 4;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    wb_arbiter_if #(.DATA_WIDTH(DW)) bif ();

    wb_arbiter #(.DATA_WIDTH(DW), .LQ_DEPTH(LQD), .STARVE_MAX(SMAX)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bif)
    );

    int n_checks = 0;
    int n_pass   = 0;

    wr_t         mq[$];
    wr_t         exp_q[$];
    int          starve = 0;
    logic [31:0] mbusy  = 32'd0;
    wr_t         mon_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic drive_idle();
        bif.alu_valid_i   = 1'b0;
        bif.alu_rd_i      = 5'd0;
        bif.alu_data_i    = 32'd0;
        bif.ld_issue_i    = 1'b0;
        bif.ld_issue_rd_i = 5'd0;
        bif.ld_valid_i    = 1'b0;
        bif.ld_rd_i       = 5'd0;
        bif.ld_data_i     = 32'd0;
    endtask

    // One clock: check state-derived outputs, drive inputs, advance the model, wait.
    task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                        input logic iss, input logic [4:0] ird,
                        input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                        output logic m_stall, output logic m_acc);
        bit  ready, keep, wr, is_ld;
        int  qsz;
        wr_t w;
        qsz     = mq.size();
        m_stall = (qsz != 0) && (starve == SMAX);
        ready   = (qsz < LQD);
        check("alu_stall", 64'(bif.alu_stall_o), 64'(m_stall));
        check("ld_ready", 64'(bif.ld_ready_o), 64'(ready));
        check("busy", 64'(bif.busy_o), 64'(mbusy));
        if (iss && ird != 5'd0) check("issue_not_busy", 64'(bif.busy_o[ird]), 64'd0);
        bif.alu_valid_i   = av;
        bif.alu_rd_i      = ard;
        bif.alu_data_i    = adat;
        bif.ld_issue_i    = iss;
        bif.ld_issue_rd_i = ird;
        bif.ld_valid_i    = lv;
        bif.ld_rd_i       = lrd;
        bif.ld_data_i     = ldat;
        m_acc = lv && ready;
        keep  = m_acc && (lrd != 5'd0);
        wr    = 1'b1;
        is_ld = 1'b1;
        w     = '0;
        if (m_stall) begin
            w = mq.pop_front();
        end else if (av && ard != 5'd0) begin
            w.rd = ard; w.data = adat; is_ld = 1'b0;
        end else if (qsz != 0) begin
            w = mq.pop_front();
        end else if (keep) begin
            w.rd = lrd; w.data = ldat; keep = 1'b0;
        end else begin
            wr = 1'b0; is_ld = 1'b0;
        end
        if (keep) begin
            wr_t p;
            p.rd = lrd; p.data = ldat;
            mq.push_back(p);
        end
        if (is_ld || qsz == 0) starve = 0;
        else if (wr) starve = (starve < SMAX) ? starve + 1 : SMAX;
        if (wr) exp_q.push_back(w);
        if (is_ld) mbusy[w.rd] = 1'b0;
        if (iss && ird != 5'd0) mbusy[ird] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        drive_idle();
    endtask

    // Called on a falling edge: asynchronous reset mid-cycle, then release.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        drive_idle();
        mq.delete();
        exp_q.delete();
        starve = 0;
        mbusy  = 32'd0;
        #1;
        check("rst_w_addr", 64'(bif.w_addr_o), 64'd0);
        check("rst_din", 64'(bif.din_o), 64'd0);
        check("rst_busy", 64'(bif.busy_o), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_stall", 64'(bif.alu_stall_o), 64'd0);
        check("rst_ready", 64'(bif.ld_ready_o), 64'd1);
        @(negedge clk);
    endtask

    // Monitor: every register-file write must match the oldest prediction.
    always @(negedge clk) begin
        if (rst_n && bif.w_addr_o != 5'd0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 64'(bif.w_addr_o), 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("w_addr", 64'(bif.w_addr_o), 64'(mon_e.rd));
                check("din", 64'(bif.din_o), 64'(mon_e.data));
            end
        end
    end

    logic        st, acc;
    logic        pa_v, pl_v;
    logic [4:0]  pa_rd, pl_rd, ird, cand;
    logic [31:0] pa_d, pl_d;
    logic        iss;
    logic [4:0]  outstanding[$];

    initial begin
        drive_idle();
        @(negedge clk);
        do_reset();

        // ALU-only writes, including a silently consumed rd=0 result.
        step(1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, st, acc);
        check("alu_basic_addr", 64'(bif.w_addr_o), 64'd3);
        check("alu_basic_din", 64'(bif.din_o), 64'h11);
        step(1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, st, acc);
        check("alu_rd0_addr", 64'(bif.w_addr_o), 64'd0);

        // Direct load: busy until the write edge.
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 1'b0, 5'd0, 32'd0, st, acc);
        check("dl_busy_set", 64'(bif.busy_o[5]), 64'd1);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd5, 32'hAB, st, acc);
        check("dl_addr", 64'(bif.w_addr_o), 64'd5);
        check("dl_din", 64'(bif.din_o), 64'hAB);
        check("dl_busy_clr", 64'(bif.busy_o[5]), 64'd0);

        // Collision with ALU, then two queued loads drain in order.
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 1'b0, 5'd0, 32'd0, st, acc);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 1'b0, 5'd0, 32'd0, st, acc);
        step(1'b1, 5'd1, 32'hA1, 1'b0, 5'd0, 1'b1, 5'd2, 32'hB2, st, acc);
        check("coll_alu_first", 64'(bif.w_addr_o), 64'd1);
        step(1'b1, 5'd7, 32'hA7, 1'b0, 5'd0, 1'b1, 5'd6, 32'hB6, st, acc);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, st, acc);
        check("coll_q_first", 64'(bif.w_addr_o), 64'd2);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, st, acc);
        check("coll_q_second", 64'(bif.w_addr_o), 64'd6);

        // Starvation: exactly SMAX ALU wins, then a forced load and the held ALU result.
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b0, 5'd0, 32'd0, st, acc);
        step(1'b1, 5'd10, 32'hC0, 1'b0, 5'd0, 1'b1, 5'd9, 32'hD9, st, acc);
        for (int k = 0; k < SMAX; k++) begin
            check("starve_no_stall", 64'(bif.alu_stall_o), 64'd0);
            step(1'b1, 5'(11 + k), 32'(k), 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, st, acc);
        end
        check("starve_stall", 64'(bif.alu_stall_o), 64'd1);
        step(1'b1, 5'd20, 32'hE0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, st, acc);
        check("starve_load_addr", 64'(bif.w_addr_o), 64'd9);
        step(1'b1, 5'd20, 32'hE0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, st, acc);
        check("starve_held_alu", 64'(bif.w_addr_o), 64'd20);

        // Full queue blocks accept; the held load goes in the cycle after a pop.
        for (int k = 21; k <= 23; k++) step(1'b0, 5'd0, 32'd0, 1'b1, 5'(k), 1'b0, 5'd0, 32'd0, st, acc);
        step(1'b1, 5'd1, 32'd1, 1'b0, 5'd0, 1'b1, 5'd21, 32'h21, st, acc);
        step(1'b1, 5'd1, 32'd2, 1'b0, 5'd0, 1'b1, 5'd22, 32'h22, st, acc);
        check("full_ready_low", 64'(bif.ld_ready_o), 64'd0);
        step(1'b1, 5'd1, 32'd3, 1'b0, 5'd0, 1'b1, 5'd23, 32'h23, st, acc);
        check("full_still_low", 64'(bif.ld_ready_o), 64'd0);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd23, 32'h23, st, acc);
        check("full_pop_addr", 64'(bif.w_addr_o), 64'd21);
        check("full_ready_after_pop", 64'(bif.ld_ready_o), 64'd1);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd23, 32'h23, st, acc);
        check("full_pop2_addr", 64'(bif.w_addr_o), 64'd22);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, st, acc);
        check("full_held_written", 64'(bif.w_addr_o), 64'd23);

        // Reset with two queued loads and busy bits outstanding.
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd24, 1'b0, 5'd0, 32'd0, st, acc);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd25, 1'b0, 5'd0, 32'd0, st, acc);
        step(1'b1, 5'd1, 32'd4, 1'b0, 5'd0, 1'b1, 5'd24, 32'h24, st, acc);
        step(1'b1, 5'd2, 32'd5, 1'b0, 5'd0, 1'b1, 5'd25, 32'h25, st, acc);
        check("pre_rst_busy", 64'(bif.busy_o), 64'h0300_0000);
        do_reset();
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, st, acc);
        check("no_stale_write", 64'(bif.w_addr_o), 64'd0);

        // Randomized traffic with realistic issue/return pairing.
        pa_v = 1'b0; pl_v = 1'b0;
        pa_rd = 5'd0; pl_rd = 5'd0; pa_d = 32'd0; pl_d = 32'd0;
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin
                do_reset();
                outstanding.delete();
                pa_v = 1'b0;
                pl_v = 1'b0;
            end
            if (!pa_v && $urandom_range(0, 9) < 7) begin
                pa_v  = 1'b1;
                pa_rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                pa_d  = $urandom;
            end
            if (!pl_v && $urandom_range(0, 9) < 5) begin
                if (outstanding.size() > 0 && $urandom_range(0, 9) < 9) begin
                    int idx;
                    idx   = int'($urandom_range(0, outstanding.size() - 1));
                    pl_rd = outstanding[idx];
                    outstanding.delete(idx);
                end else begin
                    pl_rd = 5'd0;
                end
                pl_v = 1'b1;
                pl_d = $urandom;
            end
            iss = 1'b0;
            ird = 5'd0;
            if ($urandom_range(0, 9) < 4) begin
                cand = 5'($urandom_range(1, 31));
                if (!mbusy[cand]) begin
                    iss = 1'b1;
                    ird = cand;
                    outstanding.push_back(cand);
                end
            end
            step(pa_v, pa_rd, pa_d, iss, ird, pl_v, pl_rd, pl_d, st, acc);
            if (!st) pa_v = 1'b0;
            if (acc) pl_v = 1'b0;
        end

        for (int k = 0; k < 6; k++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, st, acc);
        check("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
